pipe_event_sequencer: RTL

PIPE_EVENT_SEQUENCER -- requirements
Module: pipe_event_sequencer

---
 rtl/pipe_event_sequencer_if.sv | 37 +++
 rtl/pipe_event_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipe_event_sequencer_if.sv
// Handshake bundle between the control unit / caches and the pipeline event sequencer.
// master drives decode flags and flush completions; slave (the sequencer) drives control outputs.
interface pipe_event_sequencer_if;
   logic       instr_valid;
   logic       exception;
   logic       ret_insn;
   logic       halt;
   logic       ifence;
   logic       wfi;
   logic       interrupt_pending;
   logic       dcache_flush_done;
   logic       icache_flush_done;
   logic       stall;
   logic       flush_pipe;
   logic       trap_req;
   logic       ret_req;
   logic       wfi_wake;
   logic       dcache_flush_req;
   logic       icache_flush_req;
   logic       halted;
   logic       flush_timeout;
   logic [2:0] state;

   modport master (
      output instr_valid, exception, ret_insn, halt, ifence, wfi, interrupt_pending,
             dcache_flush_done, icache_flush_done,
      input  stall, flush_pipe, trap_req, ret_req, wfi_wake, dcache_flush_req,
             icache_flush_req, halted, flush_timeout, state
   );

   modport slave (
      input  instr_valid, exception, ret_insn, halt, ifence, wfi, interrupt_pending,
             dcache_flush_done, icache_flush_done,
      output stall, flush_pipe, trap_req, ret_req, wfi_wake, dcache_flush_req,
             icache_flush_req, halted, flush_timeout, state
   );
endinterface

// File: rtl/pipe_event_sequencer.sv
// Pipeline event sequencer: traps, returns, halt, ifence cache-flush sequence and WFI sleep.
// Flush phases are bounded by FLUSH_TIMEOUT cycles; a forced exit leaves a sticky flag.
module pipe_event_sequencer #(
   parameter int unsigned FLUSH_TIMEOUT = 200,
   parameter int unsigned CNT_W         = 8
) (
   input logic                   clk_i,
   input logic                   rst_i,
   pipe_event_sequencer_if.slave pes
);
   typedef enum logic [2:0] {
      RUN      = 3'd0,
      DFLUSH   = 3'd1,
      IFLUSH   = 3'd2,
      REFETCH  = 3'd3,
      WFI_WAIT = 3'd4,
      HALTED   = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   logic acc_v, acc_exc, acc_ret, acc_halt, acc_ifence, acc_sleep;
   logic phase_done, cnt_last;

   // Acceptance decode; only the highest-priority flag is acted on.
   always_comb begin
      acc_v      = (state_q == RUN) && pes.instr_valid;
      acc_exc    = acc_v && pes.exception;
      acc_ret    = acc_v && !pes.exception && pes.ret_insn;
      acc_halt   = acc_v && !pes.exception && !pes.ret_insn && pes.halt;
      acc_ifence = acc_v && !pes.exception && !pes.ret_insn && !pes.halt && pes.ifence;
      acc_sleep  = acc_v && !pes.exception && !pes.ret_insn && !pes.halt && !pes.ifence &&
                   pes.wfi && !pes.interrupt_pending;
      phase_done = (state_q == DFLUSH) ? pes.dcache_flush_done : pes.icache_flush_done;
      cnt_last   = (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (acc_halt) begin
                  state_q <= HALTED;
               end else if (acc_ifence) begin
                  state_q <= DFLUSH;
                  cnt_q   <= '0;
               end else if (acc_sleep) begin
                  state_q <= WFI_WAIT;
               end
            end
            DFLUSH, IFLUSH: begin
               if (phase_done || cnt_last) begin
                  state_q <= (state_q == DFLUSH) ? IFLUSH : REFETCH;
                  cnt_q   <= '0;
                  if (!phase_done) timeout_q <= 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            REFETCH:  state_q <= RUN;
            WFI_WAIT: if (pes.interrupt_pending) state_q <= RUN;
            HALTED:   state_q <= HALTED;
            default:  state_q <= RUN;
         endcase
      end
   end

   logic       stall_d, flush_d, trap_d, ret_d, wake_d, dreq_d, ireq_d, halted_d, fto_d;
   logic [2:0] state_o_d;

   // Acceptance-cycle outputs must react in the same cycle, so outputs are decoded
   // from registered state plus live inputs, and all are held low while reset is asserted.
   always_comb begin
      stall_d   = 1'b0;
      flush_d   = 1'b0;
      trap_d    = 1'b0;
      ret_d     = 1'b0;
      wake_d    = 1'b0;
      dreq_d    = 1'b0;
      ireq_d    = 1'b0;
      halted_d  = 1'b0;
      fto_d     = 1'b0;
      state_o_d = '0;
      if (!rst_i) begin
         fto_d     = timeout_q;
         state_o_d = state_q;
         case (state_q)
            RUN: begin
               trap_d  = acc_exc;
               ret_d   = acc_ret;
               flush_d = acc_exc || acc_ret;
               stall_d = acc_halt || acc_ifence || acc_sleep;
            end
            DFLUSH: begin
               stall_d = 1'b1;
               dreq_d  = 1'b1;
            end
            IFLUSH: begin
               stall_d = 1'b1;
               ireq_d  = 1'b1;
            end
            REFETCH:  flush_d = 1'b1;
            WFI_WAIT: begin
               wake_d  = pes.interrupt_pending;
               stall_d = !pes.interrupt_pending;
            end
            HALTED: begin
               stall_d  = 1'b1;
               halted_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pes.stall            = stall_d;
   assign pes.flush_pipe       = flush_d;
   assign pes.trap_req         = trap_d;
   assign pes.ret_req          = ret_d;
   assign pes.wfi_wake         = wake_d;
   assign pes.dcache_flush_req = dreq_d;
   assign pes.icache_flush_req = ireq_d;
   assign pes.halted           = halted_d;
   assign pes.flush_timeout    = fto_d;
   assign pes.state            = state_o_d;
endmodule
